// File: rtl/bin2bcd_display_feeder.sv
// rtl/bin2bcd_display_feeder.sv - sequential shift-and-add-3 binary-to-BCD converter feeding 7-segment decoders
// Outputs are held between conversions so static displays never flicker.
module bin2bcd_display_feeder #(
  parameter int W      = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_bin,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   out_digits,
  output logic [DIGITS-1:0]     out_blank,
  output logic                  out_overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(W + 1);

  function automatic logic [63:0] max_decimal(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_decimal(DIGITS);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    bin_sr;
  logic [BW-1:0]   bcd;
  logic [CW-1:0]   cnt;
  logic            ovf;

  logic            accept;
  logic            last_iter;
  logic [BW-1:0]   bcd_adj;
  logic [BW-1:0]   bcd_shift;
  logic [BW-1:0]   final_digits;
  logic [DIGITS-1:0] final_blank;
  logic            zero_above;

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign last_iter = (state == SHIFT) && (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = SHIFT;
      SHIFT:   if (last_iter) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Add-3 correction precedes the shift so each nibble stays a valid decimal digit after doubling.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    bcd_shift    = {bcd_adj[BW-2:0], bin_sr[W-1]};
    final_digits = ovf ? {DIGITS{4'h9}} : bcd_shift;
  end

  // A digit is blanked only if it and every more-significant digit are zero; digit 0 always shows.
  always_comb begin
    zero_above  = 1'b1;
    final_blank = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above     = zero_above && (final_digits[4*i +: 4] == 4'd0);
      final_blank[i] = zero_above;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_sr       <= '0;
      bcd          <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
      out_valid    <= 1'b0;
      out_digits   <= '0;
      out_overflow <= 1'b0;
      out_blank    <= ~DIGITS'(1);
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        bin_sr <= in_bin;
        bcd    <= '0;
        cnt    <= CW'(W);
        ovf    <= (64'(in_bin) > MAX_VAL);
      end else if (state == SHIFT) begin
        bin_sr <= {bin_sr[W-2:0], 1'b0};
        bcd    <= bcd_shift;
        cnt    <= cnt - CW'(1);
        if (last_iter) begin
          out_digits   <= final_digits;
          out_overflow <= ovf;
          out_blank    <= final_blank;
          out_valid    <= 1'b1;
        end
      end
    end
  end

endmodule
